// File: rtl/mc_fifo_pkg.sv
// Shared defaults, width helper and types for the multi-channel FIFO slice.
// Latency: none (declarations only). Backpressure: n/a.
// Optional error reporting is enabled with MC_FIFO_ERR_EN in the modules using this package.
package mc_fifo_pkg;

    localparam int MC_DATA_WIDTH = 8;
    localparam int MC_DEPTH      = 16;
    localparam int MC_NUM_CH     = 4;

    // Index width that never collapses to zero bits for tiny sizes.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int MC_AW  = idx_width(MC_DEPTH);
    localparam int MC_CHW = idx_width(MC_NUM_CH);

    typedef logic [MC_AW-1:0] ptr_t;
    typedef logic [MC_AW:0]   cnt_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic half_full;
        logic half_empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

endpackage

// File: rtl/mc_sync_fifo_if.sv
// Write/read request bus plus per-channel status of the multi-channel FIFO.
// Latency: n/a. Backpressure: producers watch full[], consumers watch empty[].
// err_clr/overflow/underflow exist only when MC_FIFO_ERR_EN is defined.
interface mc_sync_fifo_if
    import mc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = MC_DATA_WIDTH,
    parameter int DEPTH      = MC_DEPTH,
    parameter int NUM_CH     = MC_NUM_CH
) ();
    localparam int AW  = idx_width(DEPTH);
    localparam int CHW = idx_width(NUM_CH);

    logic                      wr_en;
    logic [CHW-1:0]            wr_ch;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      rd_en;
    logic [CHW-1:0]            rd_ch;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;
    logic [NUM_CH-1:0]         full;
    logic [NUM_CH-1:0]         empty;
    logic [NUM_CH-1:0]         half_full;
    logic [NUM_CH-1:0]         half_empty;
    logic [NUM_CH-1:0]         almost_full;
    logic [NUM_CH-1:0]         almost_empty;
    logic [NUM_CH*(AW+1)-1:0]  count;
`ifdef MC_FIFO_ERR_EN
    logic                      err_clr;
    logic [NUM_CH-1:0]         overflow;
    logic [NUM_CH-1:0]         underflow;
`endif

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch,
`ifdef MC_FIFO_ERR_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  rd_data, rd_valid, full, empty, half_full, half_empty,
        input  almost_full, almost_empty, count
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch,
`ifdef MC_FIFO_ERR_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output rd_data, rd_valid, full, empty, half_full, half_empty,
        output almost_full, almost_empty, count
    );

endinterface

// File: rtl/mc_fifo_ch_ctrl.sv
// Per-channel pointer/occupancy tracker: accepts push/pop requests, decodes status flags.
// Latency: pointers/count update on the request edge; flags follow the registered count.
// Backpressure: push refused while full, pop refused while empty (MC_FIFO_ERR_EN logs both).
module mc_fifo_ch_ctrl
    import mc_fifo_pkg::*;
#(
    parameter int DEPTH     = MC_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int AW       = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef MC_FIFO_ERR_EN
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow,
`endif
    input  logic          push_req,
    input  logic          pop_req,
    output logic          push_ok,
    output logic          pop_ok,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   count,
    output flags_t        flags
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_HALF = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_THRESH);

    assign push_ok = push_req && !flags.full;
    assign pop_ok  = pop_req  && !flags.empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            // Simultaneous accepted push and pop leaves occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        flags              = '0;
        flags.full         = (count == CNT_FULL);
        flags.empty        = (count == '0);
        flags.half_full    = (count >= CNT_HALF);
        flags.half_empty   = (count <  CNT_HALF);
        flags.almost_full  = (count >= CNT_AF);
        flags.almost_empty = (count <= CNT_AE);
    end

`ifdef MC_FIFO_ERR_EN
    // A rejection in the same cycle as err_clr keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (push_req && flags.full)  || (overflow  && !err_clr);
            underflow <= (pop_req  && flags.empty) || (underflow && !err_clr);
        end
    end
`endif

endmodule

// File: rtl/mc_sync_fifo.sv
// NUM_CH logical FIFOs in one shared array; MC_FIFO_ERR_EN adds sticky overflow/underflow.
// Latency: read data registered, rd_valid one cycle after an accepted rd_en; no write bypass.
// Backpressure: writes to a full channel and reads of an empty channel are dropped.
module mc_sync_fifo
    import mc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = MC_DATA_WIDTH,
    parameter int DEPTH      = MC_DEPTH,
    parameter int NUM_CH     = MC_NUM_CH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_sync_fifo_if.slave f
);

    localparam int AW   = idx_width(DEPTH);
    localparam int CHW  = idx_width(NUM_CH);
    localparam int CW   = AW + 1;
    localparam int ADDW = CHW + AW;

    logic [NUM_CH-1:0] push_req;
    logic [NUM_CH-1:0] pop_req;
    logic [NUM_CH-1:0] push_ok;
    logic [NUM_CH-1:0] pop_ok;
    logic [AW-1:0]     wptr_a [NUM_CH];
    logic [AW-1:0]     rptr_a [NUM_CH];
    logic [CW-1:0]     cnt_a  [NUM_CH];
    flags_t            flg_a  [NUM_CH];
`ifdef MC_FIFO_ERR_EN
    logic [NUM_CH-1:0] ovf_v;
    logic [NUM_CH-1:0] unf_v;
`endif

    logic                  wr_go;
    logic                  rd_go;
    logic [ADDW-1:0]       wr_addr;
    logic [ADDW-1:0]       rd_addr;
    logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

    // Channel numbers beyond NUM_CH match no strobe and are silently ignored.
    always_comb begin
        push_req = '0;
        pop_req  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push_req[c] = f.wr_en && (f.wr_ch == CHW'(c));
            pop_req[c]  = f.rd_en && (f.rd_ch == CHW'(c));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mc_fifo_ch_ctrl #(
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH),
            .AE_THRESH (AE_THRESH)
        ) u_ctrl (
            .clk       (clk),
            .rst_n     (rst_n),
`ifdef MC_FIFO_ERR_EN
            .err_clr   (f.err_clr),
            .overflow  (ovf_v[c]),
            .underflow (unf_v[c]),
`endif
            .push_req  (push_req[c]),
            .pop_req   (pop_req[c]),
            .push_ok   (push_ok[c]),
            .pop_ok    (pop_ok[c]),
            .wptr      (wptr_a[c]),
            .rptr      (rptr_a[c]),
            .count     (cnt_a[c]),
            .flags     (flg_a[c])
        );
    end

    // At most one channel strobe is active per port, so the loop acts as a one-hot mux.
    always_comb begin
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_ok[c]) begin
                wr_go   = 1'b1;
                wr_addr = {CHW'(c), wptr_a[c]};
            end
            if (pop_ok[c]) begin
                rd_go   = 1'b1;
                rd_addr = {CHW'(c), rptr_a[c]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_addr] <= f.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f.rd_data  <= '0;
            f.rd_valid <= 1'b0;
        end else begin
            f.rd_valid <= rd_go;
            if (rd_go) f.rd_data <= mem[rd_addr];
        end
    end

    always_comb begin
        f.full         = '0;
        f.empty        = '0;
        f.half_full    = '0;
        f.half_empty   = '0;
        f.almost_full  = '0;
        f.almost_empty = '0;
        f.count        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            f.full[c]           = flg_a[c].full;
            f.empty[c]          = flg_a[c].empty;
            f.half_full[c]      = flg_a[c].half_full;
            f.half_empty[c]     = flg_a[c].half_empty;
            f.almost_full[c]    = flg_a[c].almost_full;
            f.almost_empty[c]   = flg_a[c].almost_empty;
            f.count[c*CW +: CW] = cnt_a[c];
        end
    end

`ifdef MC_FIFO_ERR_EN
    assign f.overflow  = ovf_v;
    assign f.underflow = unf_v;
`endif

endmodule

// File: tb/tb_mc_sync_fifo.sv
// Self-checking bench for mc_sync_fifo: vector table, directed corner sequences and a
// per-channel queue model with a read scoreboard; MC_FIFO_ERR_EN adds error-bit sequences.
module tb_mc_sync_fifo;
    import mc_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NCH   = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CHW   = $clog2(NCH);
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) f ();

    mc_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .f     (f)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NCH][$];
    logic [DW-1:0] exp_rd [$];

    typedef struct {
        bit          we;
        int          wc;
        logic [7:0]  wd;
        bit          re;
        int          rc;
        bit          ev;
        logic [7:0]  ed;
        int          cc;
        int          ec;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH*(AW+1)-1:0] c;
        logic [NCH-1:0] fu, em, hf, he, af, ae;
        int n;
        for (int i = 0; i < NCH; i++) begin
            n = mq[i].size();
            c[i*(AW+1) +: AW+1] = (AW+1)'(n);
            fu[i] = (n == DEPTH);
            em[i] = (n == 0);
            hf[i] = (n >= DEPTH/2);
            he[i] = (n <  DEPTH/2);
            af[i] = (n >= AFT);
            ae[i] = (n <= AET);
        end
        chk({tag, " count"},        f.count,        c);
        chk({tag, " full"},         f.full,         fu);
        chk({tag, " empty"},        f.empty,        em);
        chk({tag, " half_full"},    f.half_full,    hf);
        chk({tag, " half_empty"},   f.half_empty,   he);
        chk({tag, " almost_full"},  f.almost_full,  af);
        chk({tag, " almost_empty"}, f.almost_empty, ae);
    endtask

    // Drive one cycle at a negedge, update the model with pre-edge acceptance,
    // then compare outputs at the following negedge.
    task automatic step(input bit we, input int wc, input logic [DW-1:0] wd,
                        input bit re, input int rc);
        bit wacc, racc;
        wacc = we && (wc < NCH) && (mq[wc].size() < DEPTH);
        racc = re && (rc < NCH) && (mq[rc].size() > 0);
        if (racc) exp_rd.push_back(mq[rc].pop_front());
        if (wacc) mq[wc].push_back(wd);
        f.wr_en   = we;
        f.wr_ch   = CHW'(wc);
        f.wr_data = wd;
        f.rd_en   = re;
        f.rd_ch   = CHW'(rc);
        @(posedge clk);
        @(negedge clk);
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        chk("rd_valid", f.rd_valid, racc);
        if (racc && exp_rd.size() > 0) chk("rd_data", f.rd_data, exp_rd.pop_front());
        check_all("step");
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        exp_rd.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        f.wr_en = 1'b0; f.wr_ch = '0; f.wr_data = '0;
        f.rd_en = 1'b0; f.rd_ch = '0;
`ifdef MC_FIFO_ERR_EN
        f.err_clr = 1'b0;
`endif
        tv[0] = '{1, 1, 8'h55, 1, 1, 0, 8'h00, 1, 1};
        tv[1] = '{1, 1, 8'h66, 1, 1, 1, 8'h55, 1, 1};
        tv[2] = '{0, 0, 8'h00, 1, 1, 1, 8'h66, 1, 0};
        tv[3] = '{0, 0, 8'h00, 1, 1, 0, 8'h66, 1, 0};
        tv[4] = '{1, 3, 8'h77, 1, 3, 0, 8'h66, 3, 1};
        tv[5] = '{1, 0, 8'h88, 1, 3, 1, 8'h77, 3, 0};
        tv[6] = '{0, 0, 8'h00, 1, 0, 1, 8'h88, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst empty", f.empty, 4'hF);
        chk("rst full", f.full, 4'h0);
        chk("rst count", f.count, '0);
        chk("rst rd_valid", f.rd_valid, 1'b0);
        chk("rst rd_data", f.rd_data, 8'h00);
`ifdef MC_FIFO_ERR_EN
        chk("rst overflow", f.overflow, 4'h0);
        chk("rst underflow", f.underflow, 4'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        // Vector table: same-channel wr+rd, hold on empty read, cross-channel independence
        for (int i = 0; i < 7; i++) begin
            step(tv[i].we, tv[i].wc, tv[i].wd, tv[i].re, tv[i].rc);
            chk("tv rd_valid", f.rd_valid, tv[i].ev);
            chk("tv rd_data", f.rd_data, tv[i].ed);
            chk("tv count", f.count[tv[i].cc*(AW+1) +: AW+1], (AW+1)'(tv[i].ec));
        end

        // Fill ch2, watch almost_full threshold, then overfill
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 2, 8'(8'h10 + i), 0, 0);
            chk("fill almost_full2", f.almost_full[2], (i + 1 >= AFT));
        end
        chk("fill full2", f.full[2], 1'b1);
        chk("fill others empty", f.empty & 4'hB, 4'hB);
        step(1, 2, 8'hEE, 0, 0);
        chk("overfill count2", f.count[2*(AW+1) +: AW+1], 5'd16);

        // Drain ch2 in order
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 8'h00, 1, 2);
            chk("drain data", f.rd_data, 8'(8'h10 + i));
        end
        chk("drain empty2", f.empty[2], 1'b1);
        step(0, 0, 8'h00, 1, 2);
        chk("drain extra rd_valid", f.rd_valid, 1'b0);
        chk("drain extra hold", f.rd_data, 8'h1F);

        // Interleaved ch0/ch3 traffic wrapping pointers several times
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) step(1, 0, 8'(8'hA0 + i/2), i >= 4, 3);
            else            step(1, 3, 8'(8'hB0 + i/2), i >= 4, 0);
        end
        while (mq[0].size() > 0) step(0, 0, 8'h00, 1, 0);
        while (mq[3].size() > 0) step(0, 0, 8'h00, 1, 3);

        // Random mixed traffic, biased towards writes to reach full states
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), int'($urandom_range(0, NCH-1)), DW'($urandom),
                 ($urandom_range(0, 9) < 4), int'($urandom_range(0, NCH-1)));
        end
        for (int c = 0; c < NCH; c++) begin
            while (mq[c].size() > 0) step(0, 0, 8'h00, 1, c);
        end

`ifdef MC_FIFO_ERR_EN
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 0, 8'hFF, 0, 0);
        chk("err overflow set", f.overflow, 4'h1);
        step(0, 0, 8'h00, 1, 1);
        chk("err underflow set", f.underflow, 4'h2);
        f.err_clr = 1'b1;
        step(0, 0, 8'h00, 0, 0);
        f.err_clr = 1'b0;
        chk("err clr overflow", f.overflow, 4'h0);
        chk("err clr underflow", f.underflow, 4'h0);
        f.err_clr = 1'b1;
        step(1, 0, 8'hFF, 0, 0);
        f.err_clr = 1'b0;
        chk("err set wins", f.overflow, 4'h1);
        step(0, 0, 8'h00, 1, 2);
        chk("err underflow2", f.underflow, 4'h4);
`endif

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'hC0 + i), (i == 3), 0);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("midrst");
        chk("midrst rd_valid", f.rd_valid, 1'b0);
        chk("midrst rd_data", f.rd_data, 8'h00);
`ifdef MC_FIFO_ERR_EN
        chk("midrst overflow", f.overflow, 4'h0);
        chk("midrst underflow", f.underflow, 4'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 0, 8'h5A, 1, 0);
        chk("postrst empty read", f.rd_valid, 1'b0);
        step(0, 0, 8'h00, 1, 0);
        chk("postrst data", f.rd_data, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
